// File: rtl/gba_line_writer.sv
// GBA pixel stream capture into the 4-slot HDMI line cache.
// Producer side of the line handshake: tracks completed lines, gates reader advance.
module gba_line_writer #(
   parameter int LINE_PIXELS = 240,
   parameter int FRAME_LINES = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsyncIn,
   input  logic        pxlValidIn,
   input  logic [4:0]  redIn,
   input  logic [4:0]  greenIn,
   input  logic [4:0]  blueIn,
   input  logic        nextLine,
   output logic        wrEn,
   output logic [9:0]  wrAddr,
   output logic [14:0] wrData,
   output logic [1:0]  readSlot,
   output logic        sameLine,
   output logic        newFrame,
   output logic        overflow
);

   localparam logic [7:0] LAST_PXL  = 8'(LINE_PIXELS - 1);
   localparam logic [7:0] LAST_LINE = 8'(FRAME_LINES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DONE
   } state_t;

   state_t     state;
   logic       vsync_d;
   logic [7:0] pxl_cnt;
   logic [7:0] line_cnt;
   logic [1:0] wr_slot;
   logic [2:0] avail_cnt;

   logic vsync_rise;
   logic capture;
   logic line_done;
   logic accept;

   assign vsync_rise = vsyncIn & ~vsync_d;
   assign capture    = (state == ACTIVE) & pxlValidIn & ~vsync_rise;
   assign line_done  = capture & (pxl_cnt == LAST_PXL);
   assign accept     = nextLine & ~sameLine & ~vsync_rise;

   // availCnt counts complete lines from readSlot onward
   assign sameLine = (avail_cnt < 3'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         vsync_d   <= 1'b0;
         pxl_cnt   <= '0;
         line_cnt  <= '0;
         wr_slot   <= '0;
         avail_cnt <= '0;
         readSlot  <= '0;
         wrEn      <= 1'b0;
         wrAddr    <= '0;
         wrData    <= '0;
         newFrame  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         vsync_d <= vsyncIn;
         wrEn    <= 1'b0;
         if (vsync_rise) begin
            state     <= ACTIVE;
            pxl_cnt   <= '0;
            line_cnt  <= '0;
            wr_slot   <= '0;
            avail_cnt <= '0;
            readSlot  <= '0;
            newFrame  <= 1'b1;
         end else begin
            if (capture) begin
               wrEn   <= 1'b1;
               wrAddr <= {wr_slot, pxl_cnt};
               wrData <= {redIn, greenIn, blueIn};
               if (line_done) begin
                  pxl_cnt  <= '0;
                  wr_slot  <= wr_slot + 2'd1;
                  line_cnt <= line_cnt + 8'd1;
                  if (line_cnt == 8'd0)
                     newFrame <= 1'b0;
                  if (line_cnt == LAST_LINE)
                     state <= DONE;
               end else begin
                  pxl_cnt <= pxl_cnt + 8'd1;
               end
            end
            if (accept)
               readSlot <= readSlot + 2'd1;
            // completion and accepted advance in one cycle cancel out
            unique case ({line_done, accept})
               2'b10: begin
                  if (avail_cnt >= 3'd2)
                     overflow <= 1'b1;
                  if (avail_cnt != 3'd3)
                     avail_cnt <= avail_cnt + 3'd1;
               end
               2'b01: avail_cnt <= avail_cnt - 3'd1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gba_line_writer.sv
// Bench for gba_line_writer: reset/startup vector table, directed line
// handshake sequences and a randomized full frame against a reference model.
module tb_gba_line_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vsyncIn = 1'b0;
   logic        pxlValidIn = 1'b0;
   logic [4:0]  redIn = '0;
   logic [4:0]  greenIn = '0;
   logic [4:0]  blueIn = '0;
   logic        nextLine = 1'b0;
   logic        wrEn;
   logic [9:0]  wrAddr;
   logic [14:0] wrData;
   logic [1:0]  readSlot;
   logic        sameLine;
   logic        newFrame;
   logic        overflow;

   gba_line_writer dut (
      .clk(clk), .rst(rst), .vsyncIn(vsyncIn), .pxlValidIn(pxlValidIn),
      .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn), .nextLine(nextLine),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .readSlot(readSlot),
      .sameLine(sameLine), .newFrame(newFrame), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model: phase 0 idle, 1 capturing, 2 frame done
   int m_phase, m_pxl, m_line, m_ws, m_rs, m_avail, m_addr, m_data;
   bit m_nf, m_ovf, m_vprev, m_we;

   task automatic model_reset();
      m_phase = 0; m_pxl = 0; m_line = 0; m_ws = 0; m_rs = 0;
      m_avail = 0; m_addr = 0; m_data = 0;
      m_nf = 0; m_ovf = 0; m_vprev = 0; m_we = 0;
   endtask

   task automatic model_edge();
      bit rise, complete, acc;
      rise = vsyncIn && !m_vprev;
      m_vprev = vsyncIn;
      m_we = 0;
      if (rise) begin
         m_phase = 1; m_pxl = 0; m_line = 0; m_ws = 0; m_rs = 0;
         m_avail = 0; m_nf = 1;
      end else begin
         complete = 0;
         acc = nextLine && (m_avail >= 2);
         if (m_phase == 1 && pxlValidIn) begin
            m_we = 1;
            m_addr = m_ws * 256 + m_pxl;
            m_data = {redIn, greenIn, blueIn};
            if (m_pxl == 239) begin
               complete = 1;
               m_pxl = 0;
               m_ws = (m_ws + 1) % 4;
               m_line++;
               if (m_line == 1) m_nf = 0;
               if (m_line == 160) m_phase = 2;
            end else begin
               m_pxl++;
            end
         end
         if (acc) m_rs = (m_rs + 1) % 4;
         if (complete && !acc) begin
            if (m_avail == 2) m_ovf = 1;
            if (m_avail < 3) m_avail++;
         end else if (acc && !complete) begin
            m_avail--;
         end
      end
   endtask

   task automatic compare_all(string tag);
      vectors++;
      if (wrEn !== m_we || wrAddr !== 10'(m_addr) || wrData !== 15'(m_data) ||
          readSlot !== 2'(m_rs) || sameLine !== (m_avail < 2) ||
          newFrame !== m_nf || overflow !== m_ovf) begin
         miscompares++;
         $display("FAIL %s t=%0t got we=%b a=%h d=%h rs=%0d sl=%b nf=%b ov=%b want we=%b a=%h d=%h rs=%0d sl=%b nf=%b ov=%b",
                  tag, $time, wrEn, wrAddr, wrData, readSlot, sameLine, newFrame, overflow,
                  m_we, 10'(m_addr), 15'(m_data), m_rs, (m_avail < 2), m_nf, m_ovf);
      end
   endtask

   task automatic chk(string name, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s got %0d want %0d", name, got, exp);
      end
   endtask

   task automatic drive(bit vs, bit pv, logic [14:0] rgb, bit nx);
      vsyncIn = vs;
      pxlValidIn = pv;
      {redIn, greenIn, blueIn} = rgb;
      nextLine = nx;
      @(posedge clk);
      model_edge();
      #1 compare_all("cycle");
   endtask

   task automatic pulse_vsync();
      drive(0, 0, 15'h0, 0);
      drive(1, 0, 15'h0, 0);
      drive(0, 0, 15'h0, 0);
   endtask

   task automatic line_px(int first, int n, bit nx_last);
      for (int i = 0; i < n; i++)
         drive(0, 1, 15'(first + i), (i == n - 1) && nx_last);
   endtask

   task automatic check_reset_outputs(string name);
      chk({name, "_wren"}, int'(wrEn), 0);
      chk({name, "_addr"}, int'(wrAddr), 0);
      chk({name, "_data"}, int'(wrData), 0);
      chk({name, "_rslot"}, int'(readSlot), 0);
      chk({name, "_same"}, int'(sameLine), 1);
      chk({name, "_nf"}, int'(newFrame), 0);
      chk({name, "_ovf"}, int'(overflow), 0);
   endtask

   typedef struct {
      bit          vs, pv, nx;
      logic [14:0] rgb;
      bit          ewe;
      logic [9:0]  eaddr;
      logic [14:0] edata;
      bit          enf, esl;
      logic [1:0]  ers;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int guard;
      int w;
      tbl[0] = '{1, 1, 0, 15'h7FFF, 0, 10'd0, 15'h0000, 1, 1, 2'd0};
      tbl[1] = '{1, 1, 0, 15'h0015, 1, 10'd0, 15'h0015, 1, 1, 2'd0};
      tbl[2] = '{0, 0, 0, 15'h3333, 0, 10'd0, 15'h0015, 1, 1, 2'd0};
      tbl[3] = '{0, 1, 0, 15'h7FFF, 1, 10'd1, 15'h7FFF, 1, 1, 2'd0};
      tbl[4] = '{0, 1, 1, 15'h1234, 1, 10'd2, 15'h1234, 1, 1, 2'd0};
      tbl[5] = '{1, 1, 0, 15'h0AAA, 0, 10'd2, 15'h1234, 1, 1, 2'd0};
      tbl[6] = '{1, 1, 0, 15'h0042, 1, 10'd0, 15'h0042, 1, 1, 2'd0};

      model_reset();
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      compare_all("reset");
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].vs, tbl[i].pv, tbl[i].rgb, tbl[i].nx);
         vectors++;
         if (wrEn !== tbl[i].ewe || wrAddr !== tbl[i].eaddr ||
             wrData !== tbl[i].edata || newFrame !== tbl[i].enf ||
             sameLine !== tbl[i].esl || readSlot !== tbl[i].ers) begin
            miscompares++;
            $display("FAIL table[%0d] got we=%b a=%h d=%h nf=%b sl=%b rs=%0d want we=%b a=%h d=%h nf=%b sl=%b rs=%0d",
                     i, wrEn, wrAddr, wrData, newFrame, sameLine, readSlot,
                     tbl[i].ewe, tbl[i].eaddr, tbl[i].edata, tbl[i].enf,
                     tbl[i].esl, tbl[i].ers);
         end
      end

      pulse_vsync();
      chk("frame_nf", int'(newFrame), 1);
      line_px(0, 240, 0);
      chk("line1_last_addr", int'(wrAddr), 239);
      chk("line1_last_data", int'(wrData), 'hEF);
      chk("line1_nf_fall", int'(newFrame), 0);
      chk("line1_same", int'(sameLine), 1);

      line_px('h100, 240, 0);
      chk("line2_same", int'(sameLine), 0);
      drive(0, 0, 15'h0, 1);
      chk("next1_rslot", int'(readSlot), 1);
      chk("next1_same", int'(sameLine), 1);
      drive(0, 0, 15'h0, 1);
      chk("next2_ignored", int'(readSlot), 1);

      line_px('h200, 240, 0);
      chk("line3_same", int'(sameLine), 0);
      line_px('h300, 240, 1);
      chk("concur_rslot", int'(readSlot), 2);
      chk("concur_same", int'(sameLine), 0);
      chk("concur_ovf", int'(overflow), 0);
      chk("concur_addr", int'(wrAddr), 'h3EF);

      line_px('h400, 100, 0);
      drive(1, 1, 15'h5555, 0);
      chk("abort_wren", int'(wrEn), 0);
      chk("abort_nf", int'(newFrame), 1);
      chk("abort_rslot", int'(readSlot), 0);
      chk("abort_same", int'(sameLine), 1);
      drive(0, 1, 15'h0777, 0);
      chk("abort_addr", int'(wrAddr), 0);
      chk("abort_wren2", int'(wrEn), 1);

      line_px('h0778, 239, 0);
      line_px('h1000, 240, 0);
      chk("lap2_ovf", int'(overflow), 0);
      line_px('h2000, 240, 0);
      chk("lap3_ovf", int'(overflow), 1);
      line_px('h3000, 240, 0);
      chk("lap4_slot", int'(wrAddr[9:8]), 3);
      chk("lap4_ovf", int'(overflow), 1);

      @(posedge clk);
      #1 rst = 1'b1;
      vsyncIn = 0; pxlValidIn = 0; nextLine = 0;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      pulse_vsync();
      guard = 0;
      while (m_phase != 2 && guard < 60000) begin
         drive(0, $urandom_range(7) != 0, 15'($urandom), 1'($urandom_range(1)));
         guard++;
      end
      chk("frame_done_in_budget", int'(guard < 60000), 1);

      w = 0;
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 15'($urandom), 0);
         w += int'(wrEn);
      end
      chk("done_no_writes", w, 0);

      pulse_vsync();
      line_px('h0123, 50, 0);
      chk("mid_wren", int'(wrEn), 1);
      drive(0, 1, 15'h7ABC, 0);
      #1 rst = 1'b1;
      #1 check_reset_outputs("async_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gba_line_writer.md
# gba_line_writer

Captures the synchronized GBA LCD pixel stream and writes it into the 4-slot line cache RAM that the HDMI image generator reads. It is the producer end of the line-cache handshake: it tracks which cached lines are complete, tells the reader via `sameLine` whether it may advance, and consumes the reader's `nextLine` pulses. It also flags frame starts with `newFrame`, which the image generator uses to realign its output raster.

## Interface
- `LINE_PIXELS`, 240: pixels per GBA line.
- `FRAME_LINES`, 160: active lines per GBA frame.
- `clk`  in  1  pixel-domain clock.
- `rst`  in  1  asynchronous, active-high reset.
- `vsyncIn`  in  1  frame marker, already synchronized to `clk`; only its rising edge is used.
- `pxlValidIn`  in  1  one-cycle strobe per GBA pixel; back-to-back strobes are legal.
- `redIn`, `greenIn`, `blueIn`  in  5 each  pixel colour, sampled when `pxlValidIn`=1.
- `nextLine`  in  1  reader request to advance to the next cached line.
- `wrEn`  out  1  cache RAM write enable.
- `wrAddr`  out  10  write address, `{slot[1:0], pxl[7:0]}`.
- `wrData`  out  15  write data, `{red, green, blue}`.
- `readSlot`  out  2  slot the reader treats as its current line.
- `sameLine`  out  1  1 when the reader must not advance because line `readSlot+1` is incomplete.
- `newFrame`  out  1  frame-start indication to the reader.
- `overflow`  out  1  sticky error: writer lapped the reader.

## Operation
- The FSM has three states:
  - IDLE: waits for a `vsyncIn` rising edge, then goes to ACTIVE.
  - ACTIVE: captures pixels.
  - DONE: reached after line `FRAME_LINES-1` completes; waits for a `vsyncIn` rising edge, then goes to ACTIVE.
- A `vsyncIn` rising edge in any state does all of the following:
  - sets `pxlCnt`, `lineCnt`, `wrSlot`, `readSlot` and `availCnt` to 0;
  - sets `newFrame` to 1;
  - goes to ACTIVE.
  - In ACTIVE it aborts any partial line; the partial line is never counted as complete.
- ACTIVE pixel capture: each `pxlValidIn` registers `wrEn`=1, `wrAddr={wrSlot,pxlCnt}` and `wrData`, then increments `pxlCnt`.
- End of line: on the pixel with `pxlCnt==LINE_PIXELS-1`:
  - `pxlCnt` wraps to 0, `wrSlot` increments mod 4 and `lineCnt` increments;
  - the line is complete, so `availCnt` increments;
  - if `lineCnt==FRAME_LINES-1`, the FSM goes to DONE.
- `pxlValidIn` in IDLE or DONE is ignored (`wrEn` stays 0).
- `availCnt` (3 bits) counts completed lines from `readSlot` onward, so `sameLine = (availCnt < 2)`.
- `nextLine` with `sameLine`=0 increments `readSlot` mod 4 and decrements `availCnt`. `nextLine` with `sameLine`=1 is ignored.
- If a line completes and `nextLine` is accepted in the same cycle, `readSlot` advances and `availCnt` is unchanged.
- Overflow: if a line completes while `availCnt==2` and no `nextLine` is accepted in that cycle, `overflow` sets. The write into the reader's previous-line slot still proceeds.
  - `overflow` clears only on `rst`.
  - `availCnt` saturates at 3.
- `newFrame` clears when the first line of the frame completes.

## Timing
- Reset values:
  - `wrEn`=0, `wrAddr`=0, `wrData`=0;
  - `readSlot`=0, `sameLine`=1, `newFrame`=0, `overflow`=0;
  - FSM in IDLE; all counters 0.
- `pxlValidIn` at cycle n produces `wrEn`/`wrAddr`/`wrData` at n+1; `wrEn` is high for exactly one cycle per accepted pixel.
- Line completion (pixel 239 at cycle n): `availCnt` and `sameLine` update at n+1, the same cycle as the final write.
- `nextLine` at cycle n: `readSlot`/`sameLine` update at n+1.
- `vsyncIn` rising at cycle n: `newFrame`=1 and counters cleared at n+1. A `pxlValidIn` at cycle n is discarded.
- `sameLine` is combinational from registered `availCnt` only.
- `newFrame` is registered.

## Test plan
- Reset, then a `vsyncIn` edge, then 240 pixels with values 0x000..0x0EF:
  - 240 writes at addresses 0..239 with matching data;
  - `newFrame` falls with the last write;
  - `sameLine` stays 1 (`availCnt`=1).
- Two full lines, then one `nextLine`:
  - `sameLine`=0 after line 2;
  - after `nextLine`, `readSlot`=1 and `sameLine`=1;
  - a second `nextLine` is ignored.
- Line completion and `nextLine` in the same cycle with `availCnt`=2: `readSlot`+1, `availCnt` stays 2, `overflow`=0.
- Four lines written with no `nextLine`: `overflow` sets on the third completion, and the fourth line's writes go to slot 3.
- `vsyncIn` edge at pixel 100 of line 5:
  - no completion is counted;
  - the next write goes to address 0 in slot 0, `readSlot`=0 and `newFrame`=1.
- After 160 lines, extra `pxlValidIn` strobes produce no writes until the next `vsyncIn` edge. Asserting `rst` mid-line returns every output to its reset value immediately.
